// File: rtl/rr_arbiter_nbit.sv
// Round-robin arbiter for 2**N requesters with registered, held grants.
// Define ARB_TIMEOUT_EN to bound grants to HOLD_LIMIT cycles and block the revoked owner.
module rr_arbiter_nbit #(
    parameter int unsigned N          = 3,
    parameter int unsigned HOLD_LIMIT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2**N-1:0]           req,
    output logic [2**N-1:0]           grant,
    output logic [(N > 0 ? N : 1)-1:0] grant_idx,
    output logic                      grant_valid,
    output logic                      timeout
);
    localparam int unsigned W  = 2 ** N;
    localparam int unsigned IW = (N > 0) ? N : 1;

    if (HOLD_LIMIT < 1 || HOLD_LIMIT > 65535) begin : g_bad_hold_limit
        $error("HOLD_LIMIT must be in 1..65535");
    end

    typedef enum logic {StIdle, StBusy} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    grant_q, grant_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [W-1:0]    block_mask;
    logic [W-1:0]    eligible;
    logic            found;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   cand;

`ifdef ARB_TIMEOUT_EN
    logic [15:0]     cnt_q, cnt_d;
    logic [W-1:0]    mask_q, mask_d;
    logic            to_q, to_d;

    assign block_mask = mask_q;
    assign timeout    = to_q;
`else
    assign block_mask = '0;
    assign timeout    = 1'b0;
`endif

    assign eligible = req & ~block_mask;

    // Rotating-priority search: first eligible bit at or after ptr, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < W; i++) begin
            cand = IW'((int'(ptr_q) + i) % W);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        mask_d  = mask_q & req;
        to_d    = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = W'(1) << pick;
                    idx_d   = pick;
                    state_d = StBusy;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StBusy: begin
                if (!req[idx_q]) begin
                    grant_d = '0;
                    idx_d   = '0;
                    ptr_d   = IW'((int'(idx_q) + 1) % W);
                    state_d = StIdle;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == 16'(HOLD_LIMIT - 1)) begin
                    // Owner still requesting after HOLD_LIMIT cycles: force it off.
                    grant_d        = '0;
                    idx_d          = '0;
                    ptr_d          = IW'((int'(idx_q) + 1) % W);
                    state_d        = StIdle;
                    mask_d[idx_q]  = 1'b1;
                    to_d           = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= '0;
            mask_q  <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            to_q    <= to_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = idx_q;
    assign grant_valid = (state_q == StBusy);

endmodule

// File: tb/tb_rr_arbiter_nbit.sv
// Self-checking bench for rr_arbiter_nbit (N=3) against a behavioural owner/pointer model.
module tb_rr_arbiter_nbit;
    localparam int N     = 3;
    localparam int W     = 8;
    localparam int LIMIT = 4;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] req;
    logic [W-1:0] grant;
    logic [N-1:0] grant_idx;
    logic         grant_valid;
    logic         timeout;

    int checks = 0;
    int errors = 0;

    // Model: who owns the resource (-1 = nobody), where the search starts, blocked requesters.
    int           m_owner;
    int           m_ptr;
    int           m_hold;
    logic [W-1:0] m_mask;
    logic         m_to;

    rr_arbiter_nbit #(
        .N          (N),
        .HOLD_LIMIT (LIMIT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic r_rst, input logic [W-1:0] r);
        logic [W-1:0] elig;
        if (r_rst) begin
            m_owner = -1; m_ptr = 0; m_hold = 0; m_mask = '0; m_to = 1'b0;
            return;
        end
        elig   = r & ~m_mask;
        m_mask = m_mask & r;
        m_to   = 1'b0;
        if (m_owner < 0) begin
            for (int i = 0; i < W; i++) begin
                if (elig[(m_ptr + i) % W]) begin
                    m_owner = (m_ptr + i) % W;
                    m_hold  = 1;
                    break;
                end
            end
        end else if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % W;
            m_owner = -1;
        end else if (TO_EN && m_hold == LIMIT) begin
            m_mask[m_owner] = 1'b1;
            m_to    = 1'b1;
            m_ptr   = (m_owner + 1) % W;
            m_owner = -1;
        end else begin
            m_hold++;
        end
    endtask

    function automatic logic [12:0] model_out();
        logic [W-1:0] g;
        logic [N-1:0] ix;
        g  = (m_owner >= 0) ? W'(1) << m_owner : '0;
        ix = (m_owner >= 0) ? N'(m_owner) : '0;
        return {g, ix, (m_owner >= 0), m_to};
    endfunction

    task automatic tick(input logic r_rst, input logic [W-1:0] r);
        rst = r_rst;
        req = r;
        @(posedge clk);
        model_step(r_rst, r);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'hFF);
            checks++;
            if ({grant, grant_idx, grant_valid} !== 12'h000) begin
                errors++;
                $display("FAIL reset_hold: got grant=%h idx=%0d valid=%b want 00/0/0",
                         grant, grant_idx, grant_valid);
            end
        end
        tick(1'b0, 8'hFF);
        checks++;
        if (grant !== 8'h01 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got grant=%h valid=%b want 01/1", grant, grant_valid);
        end
    endtask

    task automatic test_single();
        tick(1'b1, 8'h00);
        for (int i = 0; i < 6; i++) begin
            tick(1'b0, 8'b0000_0100);
            checks++;
            if (grant !== 8'b0000_0100 || grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL single_hold[%0d]: got grant=%h idx=%0d valid=%b want 04/2/1",
                         i, grant, grant_idx, grant_valid);
            end
        end
        tick(1'b0, 8'h00);
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got grant=%h valid=%b want 00/0", grant, grant_valid);
        end
    endtask

    task automatic test_round_robin();
        tick(1'b1, 8'h00);
        for (int k = 0; k < 9; k++) begin
            tick(1'b0, 8'hFF);
            checks++;
            if (grant_idx !== N'(k % W) || grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got idx=%0d valid=%b want %0d/1",
                         k, grant_idx, grant_valid, k % W);
            end
            tick(1'b0, 8'hFF & ~(8'h01 << (k % W)));
            checks++;
            if (grant_valid !== 1'b0 || grant !== 8'h00) begin
                errors++;
                $display("FAIL rr_dead[%0d]: got grant=%h valid=%b want 00/0", k, grant, grant_valid);
            end
        end
    endtask

    task automatic test_wrap();
        tick(1'b1, 8'h00);
        tick(1'b0, 8'b0100_0000);
        tick(1'b0, 8'h00);
        tick(1'b0, 8'b0000_1001);
        checks++;
        if (grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_first: got idx=%0d valid=%b want 0/1", grant_idx, grant_valid);
        end
        tick(1'b0, 8'b0000_1000);
        tick(1'b0, 8'b0000_1001);
        checks++;
        if (grant_idx !== 3'd3 || grant !== 8'b0000_1000) begin
            errors++;
            $display("FAIL wrap_second: got idx=%0d grant=%h want 3/08", grant_idx, grant);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 8'h00);
        tick(1'b0, 8'b0010_0000);
        tick(1'b1, 8'b0010_0000);
        checks++;
        if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid: got grant=%h idx=%0d valid=%b want 00/0/0",
                     grant, grant_idx, grant_valid);
        end
        tick(1'b0, 8'b0000_1010);
        checks++;
        if (grant_idx !== 3'd1 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ptr: got idx=%0d valid=%b want 1/1", grant_idx, grant_valid);
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        tick(1'b1, 8'h00);
        for (int i = 0; i < LIMIT; i++) begin
            tick(1'b0, 8'h01);
            checks++;
            if (grant_valid !== 1'b1 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_hold[%0d]: got valid=%b timeout=%b want 1/0",
                         i, grant_valid, timeout);
            end
        end
        tick(1'b0, 8'h01);
        checks++;
        if (grant_valid !== 1'b0 || timeout !== 1'b1 || grant !== 8'h00) begin
            errors++;
            $display("FAIL to_revoke: got valid=%b timeout=%b grant=%h want 0/1/00",
                     grant_valid, timeout, grant);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h01);
            checks++;
            if (grant_valid !== 1'b0 || timeout !== 1'b0) begin
                errors++;
                $display("FAIL to_blocked[%0d]: got valid=%b timeout=%b want 0/0",
                         i, grant_valid, timeout);
            end
        end
        tick(1'b0, 8'h03);
        checks++;
        if (grant_idx !== 3'd1 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL to_other: got idx=%0d valid=%b want 1/1", grant_idx, grant_valid);
        end
        tick(1'b0, 8'h02);
        tick(1'b0, 8'h01);
        tick(1'b0, 8'h01);
        checks++;
        if (grant_idx !== 3'd0 || grant_valid !== 1'b1) begin
            errors++;
            $display("FAIL to_unblock: got idx=%0d valid=%b want 0/1", grant_idx, grant_valid);
        end
    endtask
`endif

    task automatic test_random();
        logic [12:0] exp;
        logic        r_rst;
        tick(1'b1, 8'h00);
        for (int i = 0; i < 500; i++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            tick(r_rst, W'($urandom));
            exp = model_out();
            checks++;
            if ({grant, grant_idx, grant_valid, timeout} !== exp) begin
                errors++;
                $display("FAIL random[%0d]: got grant=%h idx=%0d valid=%b to=%b want %h/%0d/%b/%b",
                         i, grant, grant_idx, grant_valid, timeout,
                         exp[12:5], exp[4:2], exp[1], exp[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        model_step(1'b1, '0);
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_nbit.md
Name: rr_arbiter_nbit

Overview:
- Round-robin arbiter sharing one resource among 2**N requesters.
- Uses rotating-priority encoding: the search starts at a pointer and wraps, instead of a fixed highest-index-wins rule.
- Grant is registered and held until the owner drops its request.
- Sits in front of any shared datapath; produces a one-hot select plus a binary index for muxing.

Parameters:
- N, 3, log2 of the requester count; the block has 2**N requesters.
- HOLD_LIMIT, 16, maximum consecutive grant cycles. Used only when ARB_TIMEOUT_EN is defined. Legal range 1..65535.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  2**N  request vector; bit i is held high by requester i for the whole time it uses the resource.
- grant  output  2**N  one-hot grant, registered; all zero when idle.
- grant_idx  output  N  binary index of the owner; 0 when idle.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse on forced revocation. Tied to 0 when ARB_TIMEOUT_EN is undefined.

Behaviour:
- Reset (rst high at an edge):
  - grant=0, grant_idx=0, grant_valid=0, timeout=0.
  - ptr=0, state=IDLE, hold counter=0, block mask=0.
  - Reset overrides everything, including a grant in progress. Outputs clear at that edge.
- State IDLE:
  - eligible = req & ~block_mask.
  - If eligible is nonzero, select the first set bit scanning ptr, ptr+1, ..., 2**N-1, 0, ..., ptr-1 (modulo 2**N).
  - At that edge: register grant (one-hot), grant_idx, grant_valid=1, state becomes BUSY.
  - If eligible is zero, remain in IDLE with outputs zero.
  - Latency: req sampled high in IDLE gives grant visible after 1 edge.
- State BUSY:
  - If req[grant_idx] is 1, hold grant unchanged. Requests from other bits are ignored.
  - If req[grant_idx] is 0 at an edge: grant=0, grant_valid=0, grant_idx=0, ptr=(owner+1) mod 2**N with natural N-bit wrap, state becomes IDLE.
- Handoff: there is always exactly one dead cycle (grant_valid=0) between consecutive grants. Two grants are never active together.
- Simultaneous owner release and new requests: the release is processed first. The new grant appears on the following edge, 2 edges after the release is sampled.
- A requester that drops and re-raises req during the dead cycle competes normally. The pointer has already advanced past it.
- req changing while in BUSY (non-owner bits) has no effect until IDLE.
- If N=0 (a single requester), ptr and grant_idx are degenerate and grant=req registered with the same protocol.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- When defined:
  - A hold counter is cleared on entering BUSY and increments each BUSY cycle.
  - When grant_valid has been high for HOLD_LIMIT consecutive cycles and the owner still requests, the next edge forces revocation: grant=0, grant_valid=0, timeout=1 for one cycle, ptr=(owner+1) mod 2**N, state becomes IDLE.
  - The same edge sets block_mask[owner]=1.
  - A block_mask bit clears on any edge where the corresponding req bit is 0.
  - Normal release before the limit behaves exactly as without the macro.
- When undefined: no counter and no mask logic; block_mask is constant 0, timeout is constant 0, and grants are unbounded.

Test Plan (N=3):
1. Reset: rst=1, req=8'hFF for 3 edges -> grant=8'h00, grant_idx=0, grant_valid=0 throughout. Release rst with req=8'hFF -> grant=8'h01 after 1 edge.
2. Single request: req=8'b00000100 in IDLE -> next edge grant=8'b00000100, grant_idx=2, valid=1. Hold 5 cycles, grant stable. Drop req -> next edge grant=0, valid=0.
3. Round robin: req=8'hFF held; bench drops the owner's bit for 1 cycle after each grant -> grant_idx sequence 0,1,2,3,4,5,6,7,0, with exactly one valid=0 cycle between each pair.
4. Wrap: after owner 6 releases (ptr=7), req=8'b00001001 -> grant_idx=0 (7 not requesting, wraps to 0). After release, same req -> grant_idx=3.
5. Reset mid-grant: owner 5 active; rst=1 for 1 edge -> grant=0 at that edge. Then req=8'b00001010 -> grant_idx=1 (ptr back to 0).
6. Timeout (macro defined, HOLD_LIMIT=4): req=8'b00000001 held -> valid high exactly 4 cycles, then timeout=1 for one cycle and grant=0. Requester 0 is not regranted while req[0] stays 1. Then req=8'b00000011 -> grant_idx=1. Drop req[0] for 1 cycle and re-raise -> requester 0 is eligible again on the next arbitration.
